// File: rtl/fifo_reader_if.sv
// Handshake bundle between fifo_reader, the FIFO read port it drains and its downstream consumer.
// master is the reader's view; slave is the FIFO/consumer side.
interface fifo_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic             fifo_ren;
  logic [WIDTH-1:0] fifo_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_ren, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_ren, out_valid, out_data
  );
endinterface

// File: rtl/fifo_reader.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream via a 3-entry buffer; read-to-out_valid latency 2 cycles.
// Reads are credit-limited to occupancy+inflight <= 3, so downstream stalls never overflow the buffer.
module fifo_reader #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  fifo_reader_if.master bus,
  output logic          idle,
  output logic [15:0]   rd_count
);

  typedef logic [1:0] ptr_t;

  logic [WIDTH-1:0] mem_q [3];
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic [15:0]      rd_count_q, rd_count_d;
  logic [2:0]       credit;
  logic             ren;
  logic             pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts both buffered words and the word whose data arrives next cycle.
  assign credit = {1'b0, occ_q} + {2'b00, inflight_q};
  assign ren    = !rst && en && !bus.fifo_empty && (credit < 3'd3);
  assign pop    = (occ_q != 2'd0) && bus.out_ready;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    rd_count_d = rd_count_q;
    if (pop) begin
      head_d     = ptr_inc(head_q);
      rd_count_d = rd_count_q + 16'd1;
    end
    if (inflight_q) begin
      tail_d = ptr_inc(tail_q);
    end
    if (inflight_q && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!inflight_q && pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      rd_count_q <= 16'd0;
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= ren;
      rd_count_q <= rd_count_d;
      if (inflight_q) begin
        mem_q[tail_q] <= bus.fifo_rdata;
      end
    end
  end

  assign bus.fifo_ren  = ren;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = mem_q[head_q];
  assign idle          = (occ_q == 2'd0) && !inflight_q;
  assign rd_count      = rd_count_q;

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the team's synchronous FIFO. It drains words from the FIFO's `ren`/`empty`/`rdata` port and presents them downstream as a valid/ready stream. It absorbs the FIFO's one-cycle read latency and downstream stalls with a 3-entry internal buffer. It sits between the FIFO and any consumer that can back-pressure, such as a serializer or packet builder.

## Interface
Parameters:
- `WIDTH`, default 8: data width; must match the FIFO's data width.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high; shared with the FIFO it drains.
- `en`  input  1  when 1, new FIFO reads may be issued; when 0, no new reads are issued, but in-flight and buffered words still drain.
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_ren`  output  1  FIFO read enable.
- `fifo_rdata`  input  WIDTH  FIFO read data; valid the cycle after a read is issued.
- `out_valid`  output  1  downstream word available.
- `out_ready`  input  1  downstream accepts the word.
- `out_data`  output  WIDTH  downstream word.
- `idle`  output  1  1 when buffer occupancy is 0 and no read is in flight.
- `rd_count`  output  16  count of words delivered downstream; wraps from 0xFFFF to 0.

## Operation
- State:
  - `occ`: buffer occupancy, 0..3.
  - `inflight`: 1 bit; equals `fifo_ren` registered.
  - A 3-entry circular buffer with head and tail pointers, each 2 bits and wrapping 2 → 0.
- Read issue (combinational from registered state and `fifo_empty` only):
  - `fifo_ren = !rst && en && !fifo_empty && (occ + inflight) < 3`.
  - No combinational path from `out_ready` to `fifo_ren`.
  - `fifo_ren` is never asserted while `fifo_empty` = 1. The FIFO therefore never sees a read on empty.
- Capture: when `inflight` = 1, `fifo_rdata` is written to `buf[tail]` at the clock edge and `tail` advances.
- Output:
  - `out_valid = (occ != 0)`.
  - `out_data = buf[head]`, driven from the register; no combinational path from `fifo_rdata`.
- Pop: a transfer occurs when `out_valid && out_ready`. On a transfer, `head` advances and `rd_count` increments.
- Simultaneous capture and pop in the same cycle: `occ` is unchanged, and both pointers advance.
- Credit accounting guarantees `occ + inflight <= 3` at all times, so the buffer never overflows.
- Ordering: words leave in exactly the FIFO read order, with no loss or duplication.
- `en` deassert: takes effect on `fifo_ren` in the same cycle. A word already in flight is still captured.
- `idle = (occ == 0) && !inflight`.

## Timing
- Reset values, set at the first rising edge with `rst` = 1:
  - `occ` = 0, `inflight` = 0, `head` = `tail` = 0.
  - `out_valid` = 0, `out_data` = 0, `rd_count` = 0, `idle` = 1.
  - `fifo_ren` = 0 combinationally for as long as `rst` = 1.
- Reset mid-operation: buffered words and any in-flight word are discarded. No output is produced for them.
- Latency:
  - `fifo_ren` is asserted in cycle t.
  - `fifo_rdata` is valid and `inflight` = 1 in cycle t+1.
  - `out_valid` = 1 with that word in cycle t+2.
- Throughput: with the FIFO non-empty, `en` = 1 and `out_ready` held at 1, the block delivers one word per cycle from cycle t+2 onward. `fifo_ren` stays high continuously, with `occ + inflight` = 2 in steady state.
- Stall: with `out_ready` = 0, `fifo_ren` deasserts once `occ + inflight` reaches 3. At most 3 words are pulled beyond the last one accepted.
- Out_valid rule: `out_valid` is never withdrawn and `out_data` never changes while `out_valid` = 1 and `out_ready` = 0.
- FIFO goes empty mid-stream: `fifo_ren` drops in the same cycle `fifo_empty` rises. The buffer drains normally, and `idle` rises the cycle after the last pop.

## Test plan
- **Reset:** hold `rst` for 2 cycles with the FIFO holding 4 words → `fifo_ren` = 0, `out_valid` = 0, `rd_count` = 0, `idle` = 1 throughout.
- **Streaming:** load the FIFO with 0x11..0x18, `en` = 1, `out_ready` = 1 → `out_data` = 0x11..0x18 on 8 consecutive cycles starting 2 cycles after the first `fifo_ren`. Afterwards `rd_count` = 8, `fifo_empty` = 1, and `idle` = 1.
- **Back-pressure:** 8 words in the FIFO, `out_ready` = 0 → `fifo_ren` is high for exactly 3 cycles, then `occ` = 3. `out_data` holds 0x11 stable. After releasing `out_ready`, all 8 words are delivered in order.
- **Random stall:** 100 random bytes, `out_ready` random at 50% → output sequence equals input sequence, `rd_count` = 100, and `fifo_ren` never asserts while `fifo_empty` = 1.
- **Enable drop:** deassert `en` the cycle after a `fifo_ren` → the in-flight word is still delivered, no further reads are issued, then `idle` = 1. Reasserting `en` resumes with the next FIFO word.
- **Reset mid-burst:** assert `rst` with `occ` = 2 and `inflight` = 1 → next cycle `out_valid` = 0, `rd_count` = 0, and none of the discarded words appear at the output.
